// File: rtl/vga_pixel_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_buffer_if
// Description : CPU valid/ready bus into the VGA pixel buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_pixel_buffer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W:0]       address;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  modport master (
    output valid, address, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, address, wdata, wstrb,
    output rdata, ready
  );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_buffer
// Description : Dual-port frame buffer: VGA fetch port, CPU port, fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_buffer #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 19200,
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              reset,
  vga_pixel_buffer_if.slave      bus,
  input  wire logic [ADDR_W-1:0] pixel_addr,
  output logic      [15:0]       pixel,
  output logic                   busy
);

  localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_fill_cnt, w_fill_cnt_next;
  logic                r_done, w_done_next;
  logic                r_start;
  logic                r_ready;
  logic [15:0]         r_fill_color;
  logic [15:0]         r_pixel;
  logic [DATA_W-1:0]   r_rdata, w_rdata_next;
  logic [15:0]         r_mem [0:DEPTH-1];

  logic                w_is_reg, w_is_write, w_accept, w_ctrl_start;
  logic                w_pix_in_range, w_vga_in_range;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [1:0]          w_reg_sel;
  logic                w_b_we;
  logic [ADDR_W-1:0]   w_b_addr;
  logic [15:0]         w_b_data;
  logic [1:0]          w_b_be;
  logic                w_unused;

  assign busy           = (r_state == S_FILL);
  assign w_is_reg       = bus.address[ADDR_W];
  assign w_mem_addr     = bus.address[ADDR_W-1:0];
  assign w_reg_sel      = bus.address[1:0];
  assign w_is_write     = |bus.wstrb;
  assign w_pix_in_range = ({1'b0, w_mem_addr} < c_depth);
  assign w_vga_in_range = ({1'b0, pixel_addr} < c_depth);
  // Register accesses bypass the fill; pixel accesses wait for it.
  assign w_accept       = bus.valid && !r_ready && (w_is_reg || !busy);
  assign w_ctrl_start   = w_accept && w_is_reg && w_is_write && (w_reg_sel == 2'd0)
                          && bus.wdata[0] && !busy;
  assign w_unused       = ^{bus.wstrb[DATA_W/8-1:2], bus.wdata[DATA_W-1:16]};

  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;
  assign pixel     = r_pixel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fill_cnt   <= '0;
      r_done       <= 1'b0;
      r_start      <= 1'b0;
      r_ready      <= 1'b0;
      r_fill_color <= '0;
      r_rdata      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fill_cnt <= w_fill_cnt_next;
      r_done     <= w_done_next;
      r_start    <= w_ctrl_start;
      r_ready    <= w_accept;
      if (w_accept) begin
        r_rdata <= w_rdata_next;
      end
      if (w_accept && w_is_reg && w_is_write && (w_reg_sel == 2'd1)) begin
        r_fill_color <= bus.wdata[15:0];
      end
    end
  end

  // Fill engine owns port B whenever it runs; CPU writes only land while idle.
  always_comb begin
    w_state_next    = r_state;
    w_fill_cnt_next = r_fill_cnt;
    w_done_next     = r_done;
    w_b_we          = 1'b0;
    w_b_addr        = w_mem_addr;
    w_b_data        = bus.wdata[15:0];
    w_b_be          = bus.wstrb[1:0];
    case (r_state)
      S_IDLE: begin
        w_b_we = w_accept && !w_is_reg && w_is_write && w_pix_in_range;
        if (r_start) begin
          w_state_next    = S_FILL;
          w_fill_cnt_next = '0;
          w_done_next     = 1'b0;
        end
      end
      S_FILL: begin
        w_b_we   = 1'b1;
        w_b_addr = r_fill_cnt;
        w_b_data = r_fill_color;
        w_b_be   = 2'b11;
        if (r_fill_cnt == c_last) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_fill_cnt_next = r_fill_cnt + ADDR_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_rdata_next = '0;
    if (!w_is_write) begin
      if (w_is_reg) begin
        case (w_reg_sel)
          2'd1:    w_rdata_next = DATA_W'(r_fill_color);
          2'd2:    w_rdata_next = DATA_W'({r_done, busy});
          default: w_rdata_next = '0;
        endcase
      end else if (w_pix_in_range) begin
        w_rdata_next = DATA_W'(r_mem[w_mem_addr]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_b_we) begin
      if (w_b_be[0]) r_mem[w_b_addr][7:0]  <= w_b_data[7:0];
      if (w_b_be[1]) r_mem[w_b_addr][15:8] <= w_b_data[15:8];
    end
  end

  // Read-first: a same-cycle port B write is not visible until the next fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pixel <= '0;
    end else begin
      r_pixel <= w_vga_in_range ? r_mem[pixel_addr] : 16'h0000;
    end
  end

endmodule
`default_nettype wire
